branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of entries; power of two, range 2..256.
REQ-002 SHALL have parameter CTR_W, default 2, meaning saturating-counter width; range 1..4.
REQ-003 SHALL derive IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; every other port is synchronous to CLK.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 nRST  in  1  asynchronous active-low reset.
REQ-007 lookup_pc  in  32  fetch-stage PC; word aligned.
REQ-008 pred_taken  out  1  predicted taken (combinational from lookup_pc).
REQ-009 pred_target  out  32  predicted next PC.
REQ-010 pred_hit  out  1  valid tag match at the lookup index.
REQ-011 upd_en  in  1  pipeline enable; gates every state change except flush.
REQ-012 upd_valid  in  1  resolved branch present at update port.
REQ-013 upd_pc  in  32  PC of the resolved branch.
REQ-014 upd_taken  in  1  resolved direction.
REQ-015 upd_target  in  32  resolved taken target.
REQ-016 upd_pred_taken  in  1  direction originally predicted for this branch.
REQ-017 upd_pred_target  in  32  target originally predicted for this branch.
REQ-018 flush  in  1  invalidate all entries.
REQ-019 mispredict_cnt  out  32  saturating mispredict count.
REQ-020 update_cnt  out  32  saturating count of resolved branches.

Function
REQ-021 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; pc[1:0] is ignored.
REQ-022 Each entry SHALL hold valid, tag (TAG_W), target (32) and counter (CTR_W).
REQ-023 pred_hit SHALL be 1 iff the entry at the lookup index is valid and its tag equals the lookup tag.
REQ-024 pred_taken SHALL be pred_hit AND counter MSB.
REQ-025 pred_target SHALL be the stored target when pred_taken = 1; otherwise lookup_pc + 4, modulo 2^32.
REQ-026 Lookup SHALL have zero latency; an update in cycle N is visible to lookup from cycle N+1 only, even when the update and lookup indices are equal.
REQ-027 An update SHALL occur on a rising edge when upd_en = 1, upd_valid = 1 and flush = 0.
REQ-028 Update hit, taken: counter SHALL saturate-increment to max 2^CTR_W - 1, and target SHALL be written with upd_target.
REQ-029 Update hit, not taken: counter SHALL saturate-decrement to min 0; target SHALL be unchanged.
REQ-030 Update miss, taken: entry SHALL be overwritten with valid = 1, new tag, upd_target, and counter = 2^(CTR_W-1) (weakly taken).
REQ-031 Update miss, not taken: entry SHALL be unchanged; there is no allocation.
REQ-032 A mispredict is upd_pred_taken != upd_taken, OR (upd_taken = 1 AND upd_pred_taken = 1 AND upd_pred_target != upd_target).
REQ-033 On each update, update_cnt SHALL increment by 1; mispredict_cnt SHALL increment by 1 on a mispredict; both saturate at 0xFFFFFFFF.
REQ-034 flush = 1 SHALL clear every valid bit on the next edge regardless of upd_en; counters, targets and tags are retained.
REQ-035 flush and update in the same cycle: flush SHALL win; the update is discarded, including statistics.
REQ-036 upd_en = 0 SHALL freeze all table and statistics state, except as overridden by flush.

Reset
REQ-037 nRST low SHALL immediately force all valid = 0, all tags = 0, all targets = 0, all counters = 2^(CTR_W-1) - 1 (weakly not-taken), and mispredict_cnt = update_cnt = 0.
REQ-038 During and after reset with no updates: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
REQ-039 Reset asserted mid-update SHALL override the update; no partial entry write survives.

Verification
REQ-040 Reset, lookup_pc = 0x00000040 -> pred_hit 0, pred_taken 0, pred_target 0x00000044, both counters 0.
REQ-041 Update pc 0x40, taken, target 0x100, pred_taken 0 -> next cycle lookup 0x40: hit 1, taken 1, target 0x100; mispredict_cnt 1, update_cnt 1.
REQ-042 After REQ-041, two not-taken updates at 0x40 -> counter 2→1→0; lookup 0x40: hit 1, taken 0, target 0x44; a third not-taken update keeps counter 0.
REQ-043 Alias with ENTRIES = 16: allocate 0x40 taken→0x100, then taken update pc 0x80 target 0x200 -> lookup 0x40 hit 0, target 0x44; lookup 0x80 taken, target 0x200.
REQ-044 flush with a simultaneous taken update at 0x40 -> all hits 0 next cycle; update_cnt unchanged; upd_en = 0 with upd_valid = 1 -> no state change.
REQ-045 Preload update_cnt to 0xFFFFFFFE via updates (or force), then 3 updates -> update_cnt holds 0xFFFFFFFF; assert nRST mid-cycle -> counters read 0 asynchronously.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// zero-latency lookup and saturating update/mispredict statistics.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_hit,
  input  logic        upd_en,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        flush,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] update_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_W'(1);

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == {CTR_W{1'b0}}) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [31:0] sat32_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [31:0]        mispredict_cnt_q, mispredict_cnt_d;
  logic [31:0]        update_cnt_q, update_cnt_d;

  logic [IDX_W-1:0]   lk_idx_s;
  logic [TAG_W-1:0]   lk_tag_s;
  logic [IDX_W-1:0]   up_idx_s;
  logic [TAG_W-1:0]   up_tag_s;
  logic               up_fire_s;
  logic               up_hit_s;
  logic               mispredict_s;
  logic               unused_ok_s;

  assign lk_idx_s = lookup_pc[IDX_W+1:2];
  assign lk_tag_s = lookup_pc[31:IDX_W+2];
  assign up_idx_s = upd_pc[IDX_W+1:2];
  assign up_tag_s = upd_pc[31:IDX_W+2];
  assign unused_ok_s = ^upd_pc[1:0];

  // Lookup reads only registered state, so same-cycle updates stay invisible.
  assign pred_hit    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign pred_taken  = pred_hit && ctr_q[lk_idx_s][CTR_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx_s] : (lookup_pc + 32'd4);

  assign up_fire_s    = upd_en && upd_valid && !flush;
  assign up_hit_s     = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
  assign mispredict_s = (upd_pred_taken != upd_taken) ||
                        (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

  assign mispredict_cnt = mispredict_cnt_q;
  assign update_cnt     = update_cnt_q;

  // Next-state for table and statistics: flush dominates, then gated update.
  always_comb begin
    valid_d          = valid_q;
    tag_d            = tag_q;
    target_d         = target_q;
    ctr_d            = ctr_q;
    mispredict_cnt_d = mispredict_cnt_q;
    update_cnt_d     = update_cnt_q;
    if (flush) begin
      valid_d = {ENTRIES{1'b0}};
    end else if (up_fire_s) begin
      if (up_hit_s) begin
        if (upd_taken) begin
          ctr_d[up_idx_s]    = ctr_inc(ctr_q[up_idx_s]);
          target_d[up_idx_s] = upd_target;
        end else begin
          ctr_d[up_idx_s] = ctr_dec(ctr_q[up_idx_s]);
        end
      end else if (upd_taken) begin
        valid_d[up_idx_s]  = 1'b1;
        tag_d[up_idx_s]    = up_tag_s;
        target_d[up_idx_s] = upd_target;
        ctr_d[up_idx_s]    = CTR_WT;
      end else begin
        valid_d[up_idx_s] = valid_q[up_idx_s];
      end
      update_cnt_d = sat32_inc(update_cnt_q);
      if (mispredict_s) begin
        mispredict_cnt_d = sat32_inc(mispredict_cnt_q);
      end else begin
        mispredict_cnt_d = mispredict_cnt_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset leaves every counter weakly not-taken.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q          <= {ENTRIES{1'b0}};
      mispredict_cnt_q <= 32'd0;
      update_cnt_q     <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= {TAG_W{1'b0}};
        target_q[i] <= 32'd0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q          <= valid_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      update_cnt_q     <= update_cnt_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected lookup and
// statistics values; a negedge monitor pops and compares them.
module tb_branch_target_buffer;

  logic        CLK;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_en;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic [31:0] mispredict_cnt;
  logic [31:0] update_cnt;

  branch_target_buffer #(.ENTRIES(16), .CTR_W(2)) dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .upd_en(upd_en), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .mispredict_cnt(mispredict_cnt), .update_cnt(update_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] mcnt;
    logic [31:0] ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_id = 0;

  task automatic cmp(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL chk%0d %s: got %08h expected %08h", id, nm, got, want);
    end
  endtask

  // Queue an expectation for this cycle, then advance to just after the next edge.
  task automatic check(input logic hit, input logic taken, input logic [31:0] target,
                       input logic [31:0] mcnt, input logic [31:0] ucnt);
    exp_t e;
    e.id = next_id; e.hit = hit; e.taken = taken; e.target = target;
    e.mcnt = mcnt; e.ucnt = ucnt;
    next_id++;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the DUT at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pred_hit",       e.id, {31'd0, pred_hit},   {31'd0, e.hit});
        cmp("pred_taken",     e.id, {31'd0, pred_taken}, {31'd0, e.taken});
        cmp("pred_target",    e.id, pred_target,         e.target);
        cmp("mispredict_cnt", e.id, mispredict_cnt,      e.mcnt);
        cmp("update_cnt",     e.id, update_cnt,          e.ucnt);
      end
    end
  end

  initial begin
    nRST = 1'b0; lookup_pc = 32'h40; upd_en = 1'b1; upd_valid = 1'b0;
    upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'd0; flush = 1'b0;
    @(posedge CLK);
    #1;
    check(1'b0, 1'b0, 32'h44, 32'd0, 32'd0);
    nRST = 1'b1;
    check(1'b0, 1'b0, 32'h44, 32'd0, 32'd0);

    // Allocate, then walk the counter down to zero and back up to saturation.
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check(1'b0, 1'b0, 32'h44, 32'd0, 32'd0);
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    check(1'b1, 1'b1, 32'h100, 32'd1, 32'd1);
    set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    check(1'b1, 1'b0, 32'h44, 32'd2, 32'd2);
    set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    check(1'b1, 1'b0, 32'h44, 32'd2, 32'd3);
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check(1'b1, 1'b0, 32'h44, 32'd2, 32'd4);
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check(1'b1, 1'b0, 32'h44, 32'd3, 32'd5);
    set_upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
    check(1'b1, 1'b1, 32'h100, 32'd4, 32'd6);
    set_upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h180);
    check(1'b1, 1'b1, 32'h180, 32'd5, 32'd7);
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h180);
    check(1'b1, 1'b1, 32'h180, 32'd5, 32'd8);
    idle();
    check(1'b1, 1'b1, 32'h180, 32'd6, 32'd9);

    // Aliasing at index 0 and a not-taken miss that must not allocate.
    lookup_pc = 32'h80;
    set_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    check(1'b0, 1'b0, 32'h84, 32'd6, 32'd9);
    set_upd(32'h44, 1'b0, 32'h0, 1'b0, 32'h48);
    check(1'b1, 1'b1, 32'h200, 32'd7, 32'd10);
    idle(); lookup_pc = 32'h40;
    check(1'b0, 1'b0, 32'h44, 32'd7, 32'd11);

    // Flush beats a simultaneous update; upd_en low freezes everything.
    lookup_pc = 32'h44; flush = 1'b1;
    set_upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    check(1'b0, 1'b0, 32'h48, 32'd7, 32'd11);
    flush = 1'b0; idle(); lookup_pc = 32'h80;
    check(1'b0, 1'b0, 32'h84, 32'd7, 32'd11);
    lookup_pc = 32'h40; upd_en = 1'b0;
    set_upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    check(1'b0, 1'b0, 32'h44, 32'd7, 32'd11);
    upd_en = 1'b1;
    check(1'b0, 1'b0, 32'h44, 32'd7, 32'd11);
    idle();
    check(1'b1, 1'b1, 32'h300, 32'd8, 32'd12);
    flush = 1'b1; upd_en = 1'b0;
    check(1'b1, 1'b1, 32'h300, 32'd8, 32'd12);
    flush = 1'b0; upd_en = 1'b1; lookup_pc = 32'h3C;
    set_upd(32'h3C, 1'b1, 32'h1000, 1'b0, 32'h40);
    check(1'b0, 1'b0, 32'h40, 32'd8, 32'd12);

    // Top index, ignored low PC bits and fall-through wrap past 2^32.
    idle(); lookup_pc = 32'h3F;
    check(1'b1, 1'b1, 32'h1000, 32'd9, 32'd13);
    lookup_pc = 32'hFFFF_FFFC;
    check(1'b0, 1'b0, 32'h0, 32'd9, 32'd13);

    // Preload update_cnt near saturation, then three more updates.
    force dut.update_cnt_q = 32'hFFFF_FFFE;
    @(posedge CLK);
    #1;
    release dut.update_cnt_q;
    set_upd(32'h44, 1'b0, 32'h0, 1'b0, 32'h48);
    check(1'b0, 1'b0, 32'h0, 32'd9, 32'hFFFF_FFFE);
    check(1'b0, 1'b0, 32'h0, 32'd9, 32'hFFFF_FFFF);
    check(1'b0, 1'b0, 32'h0, 32'd9, 32'hFFFF_FFFF);
    idle();
    check(1'b0, 1'b0, 32'h0, 32'd9, 32'hFFFF_FFFF);

    // Reset dropped mid-cycle with an update pending.
    lookup_pc = 32'h3C;
    set_upd(32'h3C, 1'b1, 32'h2000, 1'b0, 32'h40);
    nRST = 1'b0;
    check(1'b0, 1'b0, 32'h40, 32'd0, 32'd0);
    idle(); nRST = 1'b1;
    check(1'b0, 1'b0, 32'h40, 32'd0, 32'd0);

    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
